// File: rtl/sysid_checker_if.sv
// rtl/sysid_checker_if.sv - read-only bus between the sysid checker and its responder
// The checker is the master; the sysid responder drives data and stall.
interface sysid_checker_if;
   logic        address;
   logic        read;
   logic [31:0] readdata;
   logic        waitrequest;

   modport master (
      output address,
      output read,
      input  readdata,
      input  waitrequest
   );

   modport slave (
      input  address,
      input  read,
      output readdata,
      output waitrequest
   );
endinterface

// File: rtl/sysid_checker.sv
// rtl/sysid_checker.sv - reads system ID and build timestamp, compares against expected values
// Each read may stall; a read stalled past TIMEOUT_CYCLES aborts the sequence with timeout set.
module sysid_checker #(
   parameter logic [31:0] EXPECTED_ID    = 32'h00000000,
   parameter logic [31:0] EXPECTED_TS    = 32'h00000000,
   parameter logic [15:0] TIMEOUT_CYCLES = 16'd255
) (
   input  logic                   clock,
   input  logic                   reset,
   input  logic                   start,
   sysid_checker_if.master        avm,
   output logic                   busy,
   output logic                   done,
   output logic                   pass,
   output logic                   id_match,
   output logic                   ts_match,
   output logic                   timeout,
   output logic [31:0]            id_value,
   output logic [31:0]            ts_value
);

   typedef enum logic [2:0] {
      IDLE,
      RD_ID,
      RD_TS,
      CHECK,
      DONE
   } state_t;

   state_t      r_state;
   state_t      w_next;
   logic [15:0] r_wait;
   logic        r_pass;
   logic        r_id_match;
   logic        r_ts_match;
   logic        r_timeout;
   logic [31:0] r_id_value;
   logic [31:0] r_ts_value;
   logic        w_reading;
   logic        w_complete;
   logic        w_expire;

   always_comb begin
      w_reading  = (r_state == RD_ID) || (r_state == RD_TS);
      w_complete = w_reading && !avm.waitrequest;
      // Expiry is evaluated on the stall cycle whose count already reached the limit.
      w_expire   = w_reading && avm.waitrequest && (r_wait == TIMEOUT_CYCLES);
      w_next     = r_state;
      case (r_state)
         IDLE:    if (start) w_next = RD_ID;
         RD_ID:   if (w_complete) w_next = RD_TS;
                  else if (w_expire) w_next = DONE;
         RD_TS:   if (w_complete) w_next = CHECK;
                  else if (w_expire) w_next = DONE;
         CHECK:   w_next = DONE;
         DONE:    w_next = IDLE;
         default: w_next = IDLE;
      endcase
   end

   assign avm.read    = w_reading;
   assign avm.address = (r_state == RD_TS);
   assign busy        = (r_state != IDLE);
   assign done        = (r_state == DONE);
   assign pass        = r_pass;
   assign id_match    = r_id_match;
   assign ts_match    = r_ts_match;
   assign timeout     = r_timeout;
   assign id_value    = r_id_value;
   assign ts_value    = r_ts_value;

   always_ff @(posedge clock) begin
      if (reset) begin
         r_state    <= IDLE;
         r_wait     <= 16'd0;
         r_pass     <= 1'b0;
         r_id_match <= 1'b0;
         r_ts_match <= 1'b0;
         r_timeout  <= 1'b0;
         r_id_value <= 32'h0;
         r_ts_value <= 32'h0;
      end else begin
         r_state <= w_next;

         if ((w_next != r_state) || w_complete) begin
            r_wait <= 16'd0;
         end else if (w_reading && avm.waitrequest) begin
            r_wait <= r_wait + 16'd1;
         end

         // Captured words are cleared too so a timed-out run never shows stale data.
         if ((r_state == IDLE) && start) begin
            r_pass     <= 1'b0;
            r_id_match <= 1'b0;
            r_ts_match <= 1'b0;
            r_timeout  <= 1'b0;
            r_id_value <= 32'h0;
            r_ts_value <= 32'h0;
         end

         if (w_complete && (r_state == RD_ID)) r_id_value <= avm.readdata;
         if (w_complete && (r_state == RD_TS)) r_ts_value <= avm.readdata;
         if (w_expire) r_timeout <= 1'b1;

         if (r_state == CHECK) begin
            r_id_match <= (r_id_value == EXPECTED_ID);
            r_ts_match <= (r_ts_value == EXPECTED_TS);
            r_pass     <= (r_id_value == EXPECTED_ID) && (r_ts_value == EXPECTED_TS) && !r_timeout;
         end
      end
   end

endmodule
